// File: rtl/parallel_dbg_pkg.sv
// parallel_dbg_pkg: shared state encoding and IR codes for the debug scan master
package parallel_dbg_pkg;
  localparam int DR_WIDTH_DEF = 38;
  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SHIFT, S_E1DR, S_RTI, S_RESP} state_e;
endpackage

// File: rtl/parallel_dbg_tck_gen.sv
// parallel_dbg_tck_gen: tck divider, low phase first, with combined fall/sample tick
module parallel_dbg_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tck_o,
  output logic fall_tick_o,
  output logic sample_tick_o
);
  localparam int CW = TCK_HALF > 1 ? $clog2(TCK_HALF) : 1;
  logic [CW-1:0] cnt_q;
  logic tck_q;
  logic wrap;
  assign wrap = en_i && cnt_q == CW'(TCK_HALF - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
      tck_q <= wrap ? ~tck_q : tck_q;
    end
  // the last clk of the high phase is both where tdo is sampled and where tck falls
  assign tck_o         = tck_q;
  assign fall_tick_o   = wrap & tck_q;
  assign sample_tick_o = wrap & tck_q;
endmodule

// File: rtl/parallel_cpu_0_cpu_debug_scan_master.sv
// parallel_cpu_0_cpu_debug_scan_master: sysclk-driven IR+DR scan initiator for the debug slave
module parallel_cpu_0_cpu_debug_scan_master
  import parallel_dbg_pkg::*;
#(
  parameter int DR_WIDTH   = DR_WIDTH_DEF,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [IR_WIDTH-1:0] cmd_ir_i,
  input  logic [DR_WIDTH-1:0] cmd_dr_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DR_WIDTH-1:0] rsp_dr_o,
  output logic [IR_WIDTH-1:0] rsp_ir_out_o,
  output logic                tck_o,
  output logic                tdi_o,
  input  logic                tdo_i,
  output logic [IR_WIDTH-1:0] ir_in_o,
  input  logic [IR_WIDTH-1:0] ir_out_i,
  output logic                vs_uir_o,
  output logic                vs_cdr_o,
  output logic                vs_sdr_o,
  output logic                vs_e1dr_o,
  output logic                jtag_state_rti_o
);
  localparam int BW = $clog2(DR_WIDTH) + 1;
  localparam int RW = $clog2(RTI_CYCLES) + 1;
  state_e state_q, state_d;
  logic                ready_q, rsp_valid_q;
  logic [IR_WIDTH-1:0] ir_q, rsp_ir_q;
  logic [DR_WIDTH-1:0] sh_q, rsp_dr_q;
  logic [BW-1:0]       bit_q;
  logic [RW-1:0]       rti_q;
  logic                busy, accept, fall, sample, last_bit, last_rti;
  assign busy     = state_q != S_IDLE && state_q != S_RESP;
  assign accept   = cmd_valid_i & cmd_ready_o;
  assign last_bit = bit_q == BW'(DR_WIDTH - 1);
  assign last_rti = rti_q == RW'(RTI_CYCLES - 1);
  parallel_dbg_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck (
    .clk          (clk),
    .rst          (rst),
    .en_i         (busy),
    .tck_o        (tck_o),
    .fall_tick_o  (fall),
    .sample_tick_o(sample)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = accept ? S_UIR : S_IDLE;
      S_UIR:   state_d = fall ? S_CDR : S_UIR;
      S_CDR:   state_d = fall ? S_SHIFT : S_CDR;
      S_SHIFT: state_d = fall && last_bit ? S_E1DR : S_SHIFT;
      S_E1DR:  state_d = fall ? S_RTI : S_E1DR;
      S_RTI:   state_d = fall && last_rti ? S_RESP : S_RTI;
      S_RESP:  state_d = rsp_valid_q && rsp_ready_i ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      ir_q        <= '0;
      rsp_ir_q    <= '0;
      sh_q        <= '0;
      rsp_dr_q    <= '0;
      bit_q       <= '0;
      rti_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      rsp_valid_q <= state_q == S_RESP && !(rsp_valid_q && rsp_ready_i);
      if (accept) begin
        ir_q <= cmd_ir_i;
        sh_q <= cmd_dr_i;
      end
      if (state_q == S_CDR && sample) rsp_ir_q <= ir_out_i;
      // tdo enters at the top so the first captured bit ends up at [0]
      if (state_q == S_SHIFT && sample) rsp_dr_q <= {tdo_i, rsp_dr_q[DR_WIDTH-1:1]};
      if (state_q == S_SHIFT && fall) begin
        sh_q  <= sh_q >> 1;
        bit_q <= last_bit ? '0 : bit_q + BW'(1);
      end
      if (state_q == S_RTI && fall) rti_q <= last_rti ? '0 : rti_q + RW'(1);
    end
  assign cmd_ready_o      = ready_q && state_q == S_IDLE;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_dr_o         = rsp_dr_q;
  assign rsp_ir_out_o     = rsp_ir_q;
  assign ir_in_o          = ir_q;
  assign tdi_o            = state_q == S_SHIFT && sh_q[0];
  assign vs_uir_o         = state_q == S_UIR;
  assign vs_cdr_o         = state_q == S_CDR;
  assign vs_sdr_o         = state_q == S_SHIFT;
  assign vs_e1dr_o        = state_q == S_E1DR;
  assign jtag_state_rti_o = state_q == S_RTI;
endmodule

// File: tb/tb_parallel_cpu_0_cpu_debug_scan_master.sv
// tb_parallel_cpu_0_cpu_debug_scan_master: scoreboard bench with a behavioural virtual-JTAG slave
module tb_parallel_cpu_0_cpu_debug_scan_master;
  localparam int DW = 38, IW = 2, TH = 2, RTI = 2;
  localparam int LAT = (3 + DW + RTI) * 2 * TH + 1;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
  logic [IW-1:0] cmd_ir = '0, rsp_ir_out, ir_in, ir_out, iro_v = '0;
  logic [DW-1:0] cmd_dr = '0, rsp_dr, sr = '0, pre_v = '0;
  logic tck, tdi, tdo = 1'b0;
  logic vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti;
  int checks = 0, fails = 0, cyc = 0, acc_cyc = 0, lat = 0;
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_e1dr = 0, n_rti = 0, n_rise = 0, n_irbad = 0;
  int b_uir = 0, b_cdr = 0, b_sdr = 0, b_e1dr = 0, b_rti = 0, b_irbad = 0;
  logic [IW-1:0] cur_ir = '0;
  logic [DW-1:0] cur_dr = '0;
  logic prev_v = 1'b0;
  typedef struct {logic [DW-1:0] rsp; logic [IW-1:0] iro;} exp_t;
  exp_t sb[$];

  parallel_cpu_0_cpu_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_HALF(TH), .RTI_CYCLES(RTI)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_ir_i(cmd_ir),
    .cmd_dr_i(cmd_dr), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dr_o(rsp_dr),
    .rsp_ir_out_o(rsp_ir_out), .tck_o(tck), .tdi_o(tdi), .tdo_i(tdo), .ir_in_o(ir_in),
    .ir_out_i(ir_out), .vs_uir_o(vs_uir), .vs_cdr_o(vs_cdr), .vs_sdr_o(vs_sdr),
    .vs_e1dr_o(vs_e1dr), .jtag_state_rti_o(rti));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave: capture-DR loads sr, shift-DR shifts on rise, tdo launched on the falling edge
  assign ir_out = vs_cdr ? iro_v : '0;
  always @(posedge tck)
    if (vs_cdr) sr <= pre_v;
    else if (vs_sdr) sr <= {tdi, sr[DW-1:1]};
  always @(negedge tck) tdo <= sr[0];
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge tck);
    n_rise++;
    n_uir += int'(vs_uir);
    n_cdr += int'(vs_cdr);
    n_sdr += int'(vs_sdr);
    n_e1dr += int'(vs_e1dr);
    n_rti += int'(rti);
    n_irbad += int'(ir_in !== cur_ir);
    if (vs_e1dr) chk("slave_sr_at_e1dr", sr, cur_dr);
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      prev_v = 1'b0;
      continue;
    end
    chk("strobe_onehot", $countones({vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti}) <= 1, 1);
    if (cmd_ready || rsp_valid) chk("idle_quiet", {tck, vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti}, 0);
    if (cmd_valid && cmd_ready) begin
      acc_cyc = cyc + 1;
      cur_ir = cmd_ir;
      cur_dr = cmd_dr;
      b_uir = n_uir; b_cdr = n_cdr; b_sdr = n_sdr; b_e1dr = n_e1dr; b_rti = n_rti; b_irbad = n_irbad;
    end
    if (rsp_valid && !prev_v) lat = cyc - acc_cyc;
    prev_v = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_dr", rsp_dr, e.rsp);
        chk("rsp_ir_out", rsp_ir_out, e.iro);
        chk("latency", lat, LAT);
        chk("uir_periods", n_uir - b_uir, 1);
        chk("cdr_periods", n_cdr - b_cdr, 1);
        chk("sdr_periods", n_sdr - b_sdr, DW);
        chk("e1dr_periods", n_e1dr - b_e1dr, 1);
        chk("rti_periods", n_rti - b_rti, RTI);
        chk("ir_in_held", n_irbad - b_irbad, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] ir, input logic [DW-1:0] dr, pre, input logic [IW-1:0] iro);
    int n = 0;
    while (!cmd_ready && n < 2000) begin step(); n++; end
    if (!cmd_ready) begin chk("cmd_ready_timeout", 0, 1); return; end
    pre_v = pre;
    iro_v = iro;
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1'b1;
    sb.push_back('{pre, iro});
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 2000) begin step(); n++; end
    if (!rsp_valid) chk("rsp_valid_timeout", 0, 1);
  endtask

  task automatic get(input int delay);
    wait_rsp();
    if (!rsp_valid) return;
    repeat (delay) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("ready_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    int bad, tot, n;
    logic [DW-1:0] pre;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tck", tck, 0);
    chk("rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti, tdi}, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_dr, rsp_ir_out, ir_in}, 0);
    step();
    rst = 1'b0;
    chk("ready_before_first_clk", cmd_ready, 0);
    repeat (20) step();
    chk("idle_tck", tck, 0);
    chk("idle_strobes", {vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti}, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);

    send(2'b10, 38'h15_DEAD_BEEF, 38'h2A_5A5A_5A5A, 2'b11);
    get(0);

    pre = {$urandom, $urandom};
    send(2'($urandom), {$urandom, $urandom}, pre, 2'($urandom));
    wait_rsp();
    bad = 0;
    tot = n_rise;
    for (int i = 0; i < 50; i++) begin
      cmd_valid = i == 10;
      cmd_dr = {$urandom, $urandom};
      if (cmd_ready || tck || !rsp_valid || rsp_dr !== pre) bad++;
      step();
    end
    cmd_valid = 1'b0;
    chk("hold_stable", bad, 0);
    chk("hold_no_tck", n_rise - tot, 0);
    get(2);

    send(2'b01, {$urandom, $urandom}, {$urandom, $urandom}, 2'b10);
    n = 0;
    while (n_sdr - b_sdr < 18 && n < 2000) begin @(negedge clk); n++; end
    chk("reached_bit17", n_sdr - b_sdr, 18);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_strobes", {tck, vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti}, 0);
    chk("midrst_rsp", {rsp_valid, rsp_dr}, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("midrst_no_e1dr", n_e1dr - b_e1dr, 0);
    send(2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 2'b01);
    get(1);

    for (int t = 0; t < 8; t++) begin
      send(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom));
      get(int'($urandom_range(0, 3)));
    end
    repeat (5) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end
endmodule
